ct_unpack: RTL and testbench
============================

CT_UNPACK -- requirements
Module: ct_unpack

Interface
REQ-001 Parameter M, default 8: GF(2^m) element width in bits.
REQ-002 Parameter DIGIT, default 8: elements per ciphertext memory word; W = M*DIGIT.
REQ-003 Parameter N, default 20: ciphertext length in elements; memory depth D = ceil(N/DIGIT).
REQ-004 Derived constant K = ceil(W/32): 32-bit stream words per memory entry.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_b  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  single-cycle request to begin receiving one ciphertext.
REQ-008 mask_in  in  512  SHA3 mask; latched on the accepted start.
REQ-009 din  in  32  masked ciphertext stream word.
REQ-010 din_valid  in  1  din holds a valid word.
REQ-011 din_ready  out  1  block accepts din this cycle.
REQ-012 ct_we  out  1  write strobe to the single-port ct memory.
REQ-013 ct_addr  out  CLOG2(D)  ct memory address.
REQ-014 ct_dout  out  W  ct memory write data.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  single-cycle pulse after the final entry is written.

Function
REQ-017 The FSM shall have four states: IDLE, RECV, WRITE and DONE.
REQ-018 IDLE: start=1 shall latch mask_in, clear the word, entry, stream and buffer counters, and move to RECV; start is ignored in every other state.
REQ-019 RECV: din_ready shall be 1; a word is accepted only on a cycle with din_valid=1 and din_ready=1.
REQ-020 Accepted word j of the entry, j = 0..K-1, shall be stored at buffer bits [32j+31:32j] as din XOR mask[32s+31:32s], where s = stream index mod 16.
REQ-021 The stream index shall count every accepted word across the whole ciphertext, starting at 0, and the mask selection shall wrap from word 15 back to word 0.
REQ-022 Buffer bits at or above W shall be discarded; for the last word, only its low W-32(K-1) bits are kept.
REQ-023 Accepting word K-1 shall move the FSM to WRITE on the next edge; din_ready shall be 0 in WRITE, DONE and IDLE.
REQ-024 WRITE shall last exactly one cycle, with ct_we=1, ct_addr equal to the entry counter and ct_dout equal to the buffer.
REQ-025 From WRITE, if the entry counter equals D-1 the FSM shall go to DONE; otherwise it shall increment the entry counter, clear the buffer and word counter, and return to RECV.
REQ-026 DONE shall last one cycle with done=1 and then return to IDLE.
REQ-027 Outside WRITE, ct_we, ct_addr and ct_dout shall be 0, so they can be OR-merged with other memory masters.
REQ-028 din_valid gaps of any length in RECV shall stall the block with no state change.
REQ-029 Minimum latency from the accepted start to done is D*(K+1)+1 cycles.

Reset
REQ-030 rst_b=1 at any edge shall force IDLE and clear all counters, the buffer and the mask register.
REQ-031 During reset, din_ready, ct_we, ct_addr, ct_dout, busy and done shall all be 0.
REQ-032 Reset during RECV or WRITE shall abort the transfer with no further write strobe.
REQ-033 After an abort, a new start shall restart the transfer at entry 0 and stream index 0.

Verification (M=8, DIGIT=8, N=20 -> W=64, K=2, D=3 unless stated)
REQ-034 Basic: mask=0, six back-to-back words 0x1..0x6 -> writes addr0=0x0000000200000001, addr1=0x0000000400000003, addr2=0x0000000600000005, then done pulses one cycle after the addr2 write.
REQ-035 Masking: mask[31:0]=0xFFFFFFFF, rest 0, words all 0 -> addr0=0x00000000FFFFFFFF, all other entries 0.
REQ-036 Wrap: N=160 (D=20, 40 words), mask words 0..15 = 0x100+i, din=0 -> stream word 16 and stream word 32 both read back as 0x100.
REQ-037 Stall/partial: M=5 (W=40, K=2), din_valid toggling 1,0,0,1, words 0xAAAAAAAA then 0xFFFFFFFF -> ct_dout=0xFFAAAAAAAA, and no write occurs during the stall cycles.
REQ-038 Reset and start: rst_b pulsed after 3 accepted words -> no further ct_we; start pulsed while busy -> ignored; a fresh start then reproduces the REQ-034 result exactly.

Source files
------------

// File: rtl/ct_unpack.sv
`default_nettype none
// ============================================================================
// Module      : ct_unpack
// Description : Receives a masked ciphertext as a stream of 32-bit words,
//               removes the SHA3 mask and packs the words into W-bit entries
//               written to a single-port ciphertext memory.
// Revision    : 1.0 - initial release
// ============================================================================
module ct_unpack #(
    parameter int M     = 8,
    parameter int DIGIT = 8,
    parameter int N     = 20,
    localparam int c_w  = M * DIGIT,
    localparam int c_d  = (N + DIGIT - 1) / DIGIT,
    localparam int c_k  = (c_w + 31) / 32,
    localparam int c_aw = (c_d > 1) ? $clog2(c_d) : 1,
    localparam int c_kw = (c_k > 1) ? $clog2(c_k) : 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic [511:0]      mask_in,
    input  logic [31:0]       din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              ct_we,
    output logic [c_aw-1:0]   ct_addr,
    output logic [c_w-1:0]    ct_dout,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [c_kw-1:0] c_last_word  = c_kw'(c_k - 1);
    localparam logic [c_aw-1:0] c_last_entry = c_aw'(c_d - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [511:0]         r_mask;
    logic [c_w-1:0]       r_buf;
    logic [c_kw-1:0]      r_word;
    logic [c_aw-1:0]      r_entry;
    logic [3:0]           r_stream;   // only the low 4 bits select a mask word

    logic [31:0]          w_mask_word;
    logic [c_k*32-1:0]    w_wide;
    logic                 w_accept;

    assign w_accept    = (r_state == S_RECV) && din_valid;
    assign w_mask_word = r_mask[{r_stream, 5'b0} +: 32];

    // Merge the unmasked word into its lane; lanes above W are dropped on truncation
    always_comb begin
        w_wide = '0;
        w_wide[c_w-1:0] = r_buf;
        w_wide[{r_word, 5'b0} +: 32] = din ^ w_mask_word;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and outputs; everything is forced low while reset is held
    always_comb begin
        w_state_nxt = r_state;
        din_ready   = 1'b0;
        ct_we       = 1'b0;
        ct_addr     = '0;
        ct_dout     = '0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = S_RECV;
            end
            S_RECV: begin
                din_ready = 1'b1;
                if (din_valid && (r_word == c_last_word)) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                ct_we   = 1'b1;
                ct_addr = r_entry;
                ct_dout = r_buf;
                w_state_nxt = (r_entry == c_last_entry) ? S_DONE : S_RECV;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (rst_b) begin
            din_ready = 1'b0;
            ct_we     = 1'b0;
            ct_addr   = '0;
            ct_dout   = '0;
            busy      = 1'b0;
            done      = 1'b0;
        end
    end

    // Mask latch, buffer packing and the word/entry/stream counters
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_mask   <= '0;
            r_buf    <= '0;
            r_word   <= '0;
            r_entry  <= '0;
            r_stream <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mask   <= mask_in;
                        r_buf    <= '0;
                        r_word   <= '0;
                        r_entry  <= '0;
                        r_stream <= '0;
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        r_buf    <= w_wide[c_w-1:0];
                        r_word   <= r_word + c_kw'(1);
                        r_stream <= r_stream + 4'd1;
                    end
                end
                S_WRITE: begin
                    if (r_entry != c_last_entry) begin
                        r_entry <= r_entry + c_aw'(1);
                        r_buf   <= '0;
                        r_word  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ct_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_unpack
// Description : Directed self-checking bench for ct_unpack (default, N=160
//               and M=5 configurations sharing one stimulus bus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_unpack;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [511:0] mask = '0;
    logic [31:0]  din = '0;
    logic         din_valid = 1'b0;

    logic         ready0, we0, busy0, done0;
    logic [1:0]   addr0;
    logic [63:0]  dout0;
    logic         ready1, we1, busy1, done1;
    logic [4:0]   addr1;
    logic [63:0]  dout1;
    logic         ready2, we2, busy2, done2;
    logic [1:0]   addr2;
    logic [39:0]  dout2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [63:0] mem0 [0:2];
    logic [63:0] mem1 [0:19];
    logic [39:0] mem2 [0:2];
    int nwe0, nwe1, nwe2, ndone0, we_cyc0, done_cyc0;

    ct_unpack u_dut0 (
        .clk(clk), .rst_b(rst), .start(start0), .mask_in(mask), .din(din),
        .din_valid(din_valid), .din_ready(ready0), .ct_we(we0), .ct_addr(addr0),
        .ct_dout(dout0), .busy(busy0), .done(done0)
    );

    ct_unpack #(.M(8), .DIGIT(8), .N(160)) u_dut1 (
        .clk(clk), .rst_b(rst), .start(start1), .mask_in(mask), .din(din),
        .din_valid(din_valid), .din_ready(ready1), .ct_we(we1), .ct_addr(addr1),
        .ct_dout(dout1), .busy(busy1), .done(done1)
    );

    ct_unpack #(.M(5), .DIGIT(8), .N(20)) u_dut2 (
        .clk(clk), .rst_b(rst), .start(start2), .mask_in(mask), .din(din),
        .din_valid(din_valid), .din_ready(ready2), .ct_we(we2), .ct_addr(addr2),
        .ct_dout(dout2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: capture every write strobe away from the clock edge
    always @(negedge clk) begin
        if (we0) begin mem0[addr0] = dout0; nwe0++; we_cyc0 = cyc; end
        if (done0) begin ndone0++; done_cyc0 = cyc; end
        if (we1) begin if (addr1 < 5'd20) mem1[addr1] = dout1; nwe1++; end
        if (we2) begin if (addr2 < 2'd3) mem2[addr2] = dout2; nwe2++; end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin mem0[i] = '0; mem2[i] = '0; end
        for (int i = 0; i < 20; i++) mem1[i] = '0;
        nwe0 = 0; nwe1 = 0; nwe2 = 0; ndone0 = 0; we_cyc0 = -100; done_cyc0 = -200;
    endtask

    // Present one word and hold it until it is accepted
    task automatic send(input logic [31:0] w);
        int t = 0;
        din = w;
        din_valid = 1'b1;
        while (!(ready0 | ready1 | ready2) && t < 50) begin tick(); t++; end
        if (t >= 50) chk("ready_timeout", 64'd0, 64'd1);
        tick();
        din_valid = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        int t = 0;
        while (((sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2) && t < 100) begin tick(); t++; end
        if (t >= 100) chk("idle_timeout", 64'd0, 64'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_model();
        repeat (3) tick();
        chk("rst_busy",  {63'd0, busy0},  64'd0);
        chk("rst_ready", {63'd0, ready0}, 64'd0);
        chk("rst_we",    {63'd0, we0},    64'd0);
        chk("rst_done",  {63'd0, done0},  64'd0);
        chk("rst_dout",  dout0,           64'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", {63'd0, busy0}, 64'd0);

        // Basic packing, unmasked
        clear_model();
        mask = '0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int i = 1; i <= 6; i++) send(32'(i));
        wait_idle(0);
        chk("basic_e0", mem0[0], 64'h0000000200000001);
        chk("basic_e1", mem0[1], 64'h0000000400000003);
        chk("basic_e2", mem0[2], 64'h0000000600000005);
        chk("basic_nwe", 64'(nwe0), 64'd3);
        chk("basic_done_gap", 64'(done_cyc0 - we_cyc0), 64'd1);
        chk("basic_done_len", 64'(ndone0), 64'd1);

        // Mask removal on stream word 0 only
        clear_model();
        mask = '0;
        mask[31:0] = 32'hFFFFFFFF;
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int i = 0; i < 6; i++) send(32'd0);
        wait_idle(0);
        chk("mask_e0", mem0[0], 64'h00000000FFFFFFFF);
        chk("mask_e1", mem0[1], 64'd0);
        chk("mask_e2", mem0[2], 64'd0);
        chk("mask_nwe", 64'(nwe0), 64'd3);

        // Mask index wraps every 16 stream words
        clear_model();
        mask = '0;
        for (int i = 0; i < 16; i++) mask[32*i +: 32] = 32'h100 + 32'(i);
        start1 = 1'b1; tick(); start1 = 1'b0;
        for (int i = 0; i < 40; i++) send(32'd0);
        wait_idle(1);
        chk("wrap_w15", {32'd0, mem1[7][63:32]},  64'h10F);
        chk("wrap_w16", {32'd0, mem1[8][31:0]},   64'h100);
        chk("wrap_w17", {32'd0, mem1[8][63:32]},  64'h101);
        chk("wrap_w32", {32'd0, mem1[16][31:0]},  64'h100);
        chk("wrap_nwe", 64'(nwe1), 64'd20);

        // Stall gaps and partial last lane (W=40)
        clear_model();
        mask = '0;
        start2 = 1'b1; tick(); start2 = 1'b0;
        din = 32'hAAAAAAAA; din_valid = 1'b1; tick();
        din_valid = 1'b0;
        chk("stall_we0", {63'd0, we2}, 64'd0);
        tick();
        chk("stall_we1", {63'd0, we2}, 64'd0);
        chk("stall_ready", {63'd0, ready2}, 64'd1);
        tick();
        din = 32'hFFFFFFFF; din_valid = 1'b1; tick();
        din_valid = 1'b0;
        chk("part_we", {63'd0, we2}, 64'd1);
        chk("part_dout", {24'd0, dout2}, 64'h000000FFAAAAAAAA);
        chk("part_nwe", 64'(nwe2), 64'd0);
        tick();
        chk("part_nwe1", 64'(nwe2), 64'd1);
        rst = 1'b1; tick(); rst = 1'b0; tick();

        // Abort mid-transfer, then ignored start while busy, then clean restart
        clear_model();
        mask = '0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        send(32'd1); send(32'd2); send(32'd3);
        rst = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy0}, 64'd0);
        chk("abort_ready", {63'd0, ready0}, 64'd0);
        tick();
        rst = 1'b0;
        din = 32'h12345678; din_valid = 1'b1;
        repeat (4) tick();
        din_valid = 1'b0;
        chk("abort_nwe", 64'(nwe0), 64'd1);
        chk("abort_idle", {63'd0, busy0}, 64'd0);

        clear_model();
        start0 = 1'b1; tick(); start0 = 1'b0;
        send(32'd1);
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int i = 2; i <= 6; i++) send(32'(i));
        wait_idle(0);
        chk("restart_e0", mem0[0], 64'h0000000200000001);
        chk("restart_e1", mem0[1], 64'h0000000400000003);
        chk("restart_e2", mem0[2], 64'h0000000600000005);
        chk("restart_nwe", 64'(nwe0), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
